// File: rtl/cpu_boot_loader.sv
// Host-side boot loader: streams an instruction/data image into the cpu memories,
// then enables the cpu for a programmed number of cycles.
module cpu_boot_loader #(
   parameter int IMEM_ADDR_W = 9,
   parameter int DMEM_ADDR_W = 10,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic             s_valid,
   input  logic [31:0]      s_data,
   output logic             s_ready,
   output logic [63:0]      imem_addr,
   output logic             imem_wen,
   output logic [31:0]      imem_wdata,
   output logic [63:0]      dmem_addr,
   output logic             dmem_wen,
   output logic [63:0]      dmem_wdata,
   output logic             cpu_enable,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] cycle_count,
   output logic [3:0]       dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE, S_IHDR, S_IWORD, S_DHDR, S_DLO, S_DHI, S_RUN, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0]          I_MAX = 17'(2 ** IMEM_ADDR_W);
   localparam logic [16:0]          D_MAX = 17'(2 ** DMEM_ADDR_W);
   localparam logic [IMEM_ADDR_W:0] I_ONE = 1;
   localparam logic [DMEM_ADDR_W:0] D_ONE = 1;
   localparam logic [CNT_W-1:0]     C_ONE = 1;

   state_t                 state;
   logic [IMEM_ADDR_W:0]   n_cnt;
   logic [IMEM_ADDR_W:0]   i_idx;
   logic [DMEM_ADDR_W:0]   m_cnt;
   logic [DMEM_ADDR_W:0]   d_idx;
   logic [31:0]            lo_half;
   logic [CNT_W-1:0]       max_cyc;

   // Ready is a pure decode of the state register, so it drops with reset.
   assign s_ready = (state == S_IHDR) || (state == S_IWORD) || (state == S_DHDR) ||
                    (state == S_DLO)  || (state == S_DHI);
   assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign dbg_state = state;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state       <= S_IDLE;
         n_cnt       <= '0;
         i_idx       <= '0;
         m_cnt       <= '0;
         d_idx       <= '0;
         lo_half     <= '0;
         max_cyc     <= '0;
         imem_addr   <= '0;
         imem_wen    <= 1'b0;
         imem_wdata  <= '0;
         dmem_addr   <= '0;
         dmem_wen    <= 1'b0;
         dmem_wdata  <= '0;
         cpu_enable  <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         cycle_count <= '0;
      end else begin
         imem_wen <= 1'b0;
         dmem_wen <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state       <= S_IHDR;
                  done        <= 1'b0;
                  err         <= 1'b0;
                  cycle_count <= '0;
                  i_idx       <= '0;
                  d_idx       <= '0;
                  max_cyc     <= max_cycles;
               end
            end
            S_IHDR: begin
               if (s_valid) begin
                  if (s_data[15:0] == 16'd0) begin
                     state <= S_DHDR;
                  end else if ({1'b0, s_data[15:0]} > I_MAX) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end else begin
                     n_cnt <= s_data[IMEM_ADDR_W:0];
                     state <= S_IWORD;
                  end
               end
            end
            S_IWORD: begin
               if (s_valid) begin
                  imem_wen   <= 1'b1;
                  imem_addr  <= {{(64-IMEM_ADDR_W-3){1'b0}}, i_idx, 2'b00};
                  imem_wdata <= s_data;
                  i_idx      <= i_idx + I_ONE;
                  if (i_idx + I_ONE == n_cnt) state <= S_DHDR;
               end
            end
            S_DHDR: begin
               if (s_valid) begin
                  if (s_data[15:0] == 16'd0) begin
                     state <= S_RUN;
                  end else if ({1'b0, s_data[15:0]} > D_MAX) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end else begin
                     m_cnt <= s_data[DMEM_ADDR_W:0];
                     state <= S_DLO;
                  end
               end
            end
            S_DLO: begin
               if (s_valid) begin
                  lo_half <= s_data;
                  state   <= S_DHI;
               end
            end
            S_DHI: begin
               if (s_valid) begin
                  dmem_wen   <= 1'b1;
                  dmem_addr  <= {{(64-DMEM_ADDR_W-4){1'b0}}, d_idx, 3'b000};
                  dmem_wdata <= {s_data, lo_half};
                  d_idx      <= d_idx + D_ONE;
                  state      <= (d_idx + D_ONE == m_cnt) ? S_RUN : S_DLO;
               end
            end
            S_RUN: begin
               // First RUN cycle keeps enable low, so the last dmem write never overlaps it.
               if (cycle_count == max_cyc) begin
                  state      <= S_DONE;
                  cpu_enable <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  cpu_enable  <= 1'b1;
                  cycle_count <= cycle_count + C_ONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Scoreboard bench for cpu_boot_loader: driver pushes expected memory writes,
// a negedge monitor pops and compares them as the loader emits them.
module tb_cpu_boot_loader;

   localparam int CNT_W = 32;

   logic             clk, arst, start, s_valid;
   logic [CNT_W-1:0] max_cycles;
   logic [31:0]      s_data;
   logic             s_ready, imem_wen, dmem_wen, cpu_enable, busy, done, err;
   logic [63:0]      imem_addr, dmem_addr, dmem_wdata;
   logic [31:0]      imem_wdata;
   logic [CNT_W-1:0] cycle_count;
   logic [3:0]       dbg_state;

   cpu_boot_loader #(.IMEM_ADDR_W(9), .DMEM_ADDR_W(10), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst(arst), .start(start), .max_cycles(max_cycles),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
      .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
      .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err),
      .cycle_count(cycle_count), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [95:0]  imem_exp_q[$];
   logic [127:0] dmem_exp_q[$];
   logic [31:0]  img_i[$];
   logic [63:0]  img_d[$];
   int n_checks = 0;
   int n_fail   = 0;
   int en_total = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write must match the head of its expected queue.
   always @(negedge clk) begin
      if (!arst) begin
         if (cpu_enable) en_total++;
         if (imem_wen) begin
            if (imem_exp_q.size() == 0) check("imem_unexpected", {imem_addr, imem_wdata}, 0);
            else check("imem_write", {imem_addr, imem_wdata}, imem_exp_q.pop_front());
            check("imem_vs_enable", cpu_enable, 0);
         end
         if (dmem_wen) begin
            if (dmem_exp_q.size() == 0) check("dmem_unexpected", {dmem_addr, dmem_wdata}, 0);
            else check("dmem_write", {dmem_addr, dmem_wdata}, dmem_exp_q.pop_front());
            check("dmem_vs_enable", cpu_enable, 0);
         end
      end
   end

   task automatic send_word(input logic [31:0] w, input bit toggle);
      bit acc;
      bit got;
      got = 1'b0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = w;
      for (int k = 0; k < 40; k++) begin
         acc = s_ready;
         @(posedge clk);
         if (acc) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) check("s_ready_timeout", got, 1);
      if (toggle) begin
         @(negedge clk);
         s_valid = 1'b0;
         s_data  = 32'hDEADBEEF;
      end
   endtask

   task automatic load_image(input bit toggle);
      send_word(32'(img_i.size()), toggle);
      for (int i = 0; i < img_i.size(); i++) begin
         send_word(img_i[i], toggle);
         imem_exp_q.push_back({64'(i * 4), img_i[i]});
      end
      send_word(32'(img_d.size()), toggle);
      for (int j = 0; j < img_d.size(); j++) begin
         send_word(img_d[j][31:0], toggle);
         send_word(img_d[j][63:32], toggle);
         dmem_exp_q.push_back({64'(j * 8), img_d[j]});
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic [CNT_W-1:0] mc);
      @(negedge clk);
      start      = 1'b1;
      max_cycles = mc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int cycles);
      cycles = 0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         cycles++;
         if (done || err) break;
      end
   endtask

   task automatic check_queues(input string tag);
      check({tag, "_imem_q_empty"}, imem_exp_q.size(), 0);
      check({tag, "_dmem_q_empty"}, dmem_exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int cyc;
      arst = 1'b0; start = 1'b0; max_cycles = '0; s_valid = 1'b0; s_data = '0;
      #3 arst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_flags", {s_ready, busy, done, err, cpu_enable, imem_wen, dmem_wen}, 0);
      check("rst_cycle_count", cycle_count, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_dmem_data", dmem_wdata, 0);
      arst = 1'b0;

      // Reset after 2 of 4 instruction words
      pulse_start(10);
      send_word(32'd4, 0);
      send_word(32'h000000A0, 0);
      imem_exp_q.push_back({64'd0, 32'h000000A0});
      send_word(32'h000000A1, 0);
      imem_exp_q.push_back({64'd4, 32'h000000A1});
      @(negedge clk);
      s_valid = 1'b0;
      check("mid_busy_before_reset", busy, 1);
      @(posedge clk);
      #2 arst = 1'b1;
      #1 check("mid_reset_flags", {s_ready, busy, done, err, cpu_enable, imem_wen, dmem_wen}, 0);
      @(negedge clk);
      arst    = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'h00000005;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_reset_s_ready", s_ready, 0);
      end
      s_valid = 1'b0;
      check_queues("mid_reset");

      // Main image, with an ignored start during RUN
      base  = en_total;
      img_i = '{32'h00500093, 32'h00100113, 32'h002081B3};
      img_d = '{64'h2222222211111111};
      pulse_start(20);
      load_image(0);
      repeat (5) @(negedge clk);
      check("run_busy", busy, 1);
      pulse_start(99);
      wait_done(60, cyc);
      check("main_done", done, 1);
      check("main_err", err, 0);
      check("main_cycle_count", cycle_count, 20);
      check("main_enable_cycles", en_total - base, 20);
      check("main_busy_after", busy, 0);
      check_queues("main");

      // Toggled s_valid
      base  = en_total;
      img_i = '{32'h11110000, 32'h11110001, 32'h11110002};
      img_d = '{64'hAAAA0001BBBB0001, 64'hAAAA0002BBBB0002};
      pulse_start(5);
      check("restart_clears_done", done, 0);
      load_image(1);
      wait_done(30, cyc);
      check("toggle_done", done, 1);
      check("toggle_cycle_count", cycle_count, 5);
      check("toggle_enable_cycles", en_total - base, 5);
      check_queues("toggle");

      // Empty image with zero run length
      base = en_total;
      pulse_start(0);
      send_word(32'd0, 0);
      send_word(32'd0, 0);
      @(negedge clk);
      s_valid = 1'b0;
      wait_done(8, cyc);
      check("zero_done", done, 1);
      check("zero_latency_ok", (cyc + 1) <= 4, 1);
      check("zero_enable_cycles", en_total - base, 0);
      check("zero_cycle_count", cycle_count, 0);

      // Oversized instruction count
      pulse_start(10);
      send_word(32'd513, 0);
      @(negedge clk);
      s_valid = 1'b0;
      wait_done(6, cyc);
      check("big_n_err", err, 1);
      check("big_n_flags", {s_ready, busy, done}, 0);
      base  = en_total;
      img_i = '{32'h00000013};
      img_d.delete();
      pulse_start(3);
      check("err_cleared", err, 0);
      load_image(0);
      wait_done(20, cyc);
      check("recover_done", done, 1);
      check("recover_err", err, 0);
      check("recover_cycle_count", cycle_count, 3);
      check("recover_enable_cycles", en_total - base, 3);
      check_queues("recover");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
